if_fetch_stage: RTL and testbench

- IF pipeline stage directly downstream of the pre-IF address stage.
- Owns the pre-IF→IF pipeline register and waits for the instruction SRAM data beat. It drops beats from squashed requests and buffers the instruction when ID stalls.
- Presents {pc, inst, exception info} to ID with a valid/allow-in handshake.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/if_fetch_stage_inst_buffer.sv | 26 ++
 rtl/if_fetch_stage.sv | 118 +++++++++++
 tb/tb_if_fetch_stage.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: IF state encoding, reset PC and IF entry payload.
package cpu_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned EXCCODE_W = 5;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFBF_FFFC;

    typedef enum logic [1:0] {
        IF_EMPTY = 2'd0,
        IF_WAIT  = 2'd1,
        IF_READY = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0]      pc;
        logic                 exception;
        logic [EXCCODE_W-1:0] exccode;
        logic                 tlb_refill;
    } if_entry_t;

endpackage

// File: rtl/if_fetch_stage_inst_buffer.sv
// Single-entry instruction holding register with bypass of the live SRAM beat.
module if_inst_buffer
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [XLEN-1:0] wdata,
    input  logic            bypass,
    input  logic [XLEN-1:0] bypass_data,
    output logic [XLEN-1:0] inst
);

    logic [XLEN-1:0] buf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q <= '0;
        end else if (we) begin
            buf_q <= wdata;
        end
    end

    assign inst = bypass ? bypass_data : buf_q;

endmodule

// File: rtl/if_fetch_stage.sv
// IF stage: pre-IF->IF register, SRAM beat wait, squashed-beat drop, ID handshake.
// Optional build macro IF_PERF_CNT_EN adds wait-cycle and discard counters.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inst_sram_data_ok,
    input  logic [XLEN-1:0]      inst_sram_rdata,
    input  logic                 leaving_pre_IF,
    input  logic [XLEN-1:0]      pc_pre_IF,
    input  logic                 exception_pre_IF,
    input  logic [EXCCODE_W-1:0] exccode_pre_IF,
    input  logic                 tlb_refill_pre_IF,
    input  logic                 discard_instruction,
    input  logic                 exception_like_now,
    output logic                 pre_IF_IF_reg_valid,
    output logic                 pre_IF_IF_reg_stall_wait_for_data,
    output logic                 IF_allow_in,
    input  logic                 ID_allow_in,
    output logic                 IF_ID_valid,
    output logic                 leaving_IF,
    output logic [XLEN-1:0]      curr_pc_IF,
    output logic [XLEN-1:0]      inst_IF,
    output logic                 exception_IF,
    output logic [EXCCODE_W-1:0] exccode_IF,
    output logic                 tlb_refill_IF
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          perf_wait_cycles,
    output logic [31:0]          perf_discards
`endif
);

    if_state_e state_q;
    if_entry_t entry_q;

    logic beat_ok;
    logic in_wait;
    logic enter;
    logic capture;

    assign beat_ok = inst_sram_data_ok & ~discard_instruction;
    assign in_wait = (state_q == IF_WAIT);
    assign enter   = leaving_pre_IF & ~exception_like_now;
    // Beat arrives while ID stalls: park it in the buffer.
    assign capture = in_wait & beat_ok & ~leaving_IF;

    assign pre_IF_IF_reg_valid               = (state_q != IF_EMPTY);
    assign pre_IF_IF_reg_stall_wait_for_data = in_wait;
    assign IF_ID_valid = ~exception_like_now & ((state_q == IF_READY) | (in_wait & beat_ok));
    assign leaving_IF  = IF_ID_valid & ID_allow_in;
    assign IF_allow_in = (state_q == IF_EMPTY) | leaving_IF;

    assign curr_pc_IF    = entry_q.pc;
    assign exception_IF  = entry_q.exception;
    assign exccode_IF    = entry_q.exccode;
    assign tlb_refill_IF = entry_q.tlb_refill;

    // State and entry register; flush wins over entry, entry wins over drain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q            <= IF_EMPTY;
            entry_q.pc         <= RESET_PC;
            entry_q.exception  <= 1'b0;
            entry_q.exccode    <= '0;
            entry_q.tlb_refill <= 1'b0;
        end else begin
            if (enter) begin
                entry_q.pc         <= pc_pre_IF;
                entry_q.exception  <= exception_pre_IF;
                entry_q.exccode    <= exccode_pre_IF;
                entry_q.tlb_refill <= tlb_refill_pre_IF;
            end
            if (exception_like_now) begin
                state_q <= IF_EMPTY;
            end else if (enter) begin
                state_q <= exception_pre_IF ? IF_READY : IF_WAIT;
            end else begin
                case (state_q)
                    IF_WAIT:  if (beat_ok) state_q <= leaving_IF ? IF_EMPTY : IF_READY;
                    IF_READY: if (leaving_IF) state_q <= IF_EMPTY;
                    default:  state_q <= IF_EMPTY;
                endcase
            end
        end
    end

    // A new entry zeroes the buffer so exception entries present inst 0.
    if_inst_buffer u_inst_buffer (
        .clk         (clk),
        .reset       (reset),
        .we          (enter | capture),
        .wdata       (enter ? '0 : inst_sram_rdata),
        .bypass      (in_wait & beat_ok),
        .bypass_data (inst_sram_rdata),
        .inst        (inst_IF)
    );

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_wait_cycles <= '0;
            perf_discards    <= '0;
        end else begin
            if (in_wait && !beat_ok && perf_wait_cycles != 32'hFFFF_FFFF) begin
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
            end
            if (inst_sram_data_ok && discard_instruction && perf_discards != 32'hFFFF_FFFF) begin
                perf_discards <= perf_discards + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven bench for if_fetch_stage with an entry scoreboard checked on leaving_IF.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        leaving_pre_IF;
    logic [31:0] pc_pre_IF;
    logic        exception_pre_IF;
    logic [4:0]  exccode_pre_IF;
    logic        tlb_refill_pre_IF;
    logic        discard_instruction;
    logic        exception_like_now;
    logic        pre_IF_IF_reg_valid;
    logic        pre_IF_IF_reg_stall_wait_for_data;
    logic        IF_allow_in;
    logic        ID_allow_in;
    logic        IF_ID_valid;
    logic        leaving_IF;
    logic [31:0] curr_pc_IF;
    logic [31:0] inst_IF;
    logic        exception_IF;
    logic [4:0]  exccode_IF;
    logic        tlb_refill_IF;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_wait_cycles;
    logic [31:0] perf_discards;
`endif

    if_fetch_stage dut (
        .clk                               (clk),
        .reset                             (reset),
        .inst_sram_data_ok                 (inst_sram_data_ok),
        .inst_sram_rdata                   (inst_sram_rdata),
        .leaving_pre_IF                    (leaving_pre_IF),
        .pc_pre_IF                         (pc_pre_IF),
        .exception_pre_IF                  (exception_pre_IF),
        .exccode_pre_IF                    (exccode_pre_IF),
        .tlb_refill_pre_IF                 (tlb_refill_pre_IF),
        .discard_instruction               (discard_instruction),
        .exception_like_now                (exception_like_now),
        .pre_IF_IF_reg_valid               (pre_IF_IF_reg_valid),
        .pre_IF_IF_reg_stall_wait_for_data (pre_IF_IF_reg_stall_wait_for_data),
        .IF_allow_in                       (IF_allow_in),
        .ID_allow_in                       (ID_allow_in),
        .IF_ID_valid                       (IF_ID_valid),
        .leaving_IF                        (leaving_IF),
        .curr_pc_IF                        (curr_pc_IF),
        .inst_IF                           (inst_IF),
        .exception_IF                      (exception_IF),
        .exccode_IF                        (exccode_IF),
        .tlb_refill_IF                     (tlb_refill_IF)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_wait_cycles                  (perf_wait_cycles),
        .perf_discards                     (perf_discards)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        li;
        logic [31:0] pc;
        logic        exc;
        logic [4:0]  code;
        logic        tlb;
        logic        push;
        logic [31:0] sb_inst;
        logic        dok;
        logic [31:0] rdata;
        logic        disc;
        logic        exl;
        logic        ida;
        logic        e_valid;
        logic        e_stall;
        logic        e_allow;
        logic        e_ifid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
        logic        tlb;
    } sb_t;

    localparam int NV = 30;
    vec_t vecs[NV];
    sb_t  sb_q[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic li, input logic [31:0] pc, input logic exc,
                                input logic [4:0] code, input logic tlb, input logic push,
                                input logic [31:0] sb_inst, input logic dok, input logic [31:0] rdata,
                                input logic disc, input logic exl, input logic ida,
                                input logic e_valid, input logic e_stall, input logic e_allow,
                                input logic e_ifid, input logic [31:0] e_pc, input logic [31:0] e_inst);
        vec_t v;
        v.li = li; v.pc = pc; v.exc = exc; v.code = code; v.tlb = tlb;
        v.push = push; v.sb_inst = sb_inst; v.dok = dok; v.rdata = rdata;
        v.disc = disc; v.exl = exl; v.ida = ida;
        v.e_valid = e_valid; v.e_stall = e_stall; v.e_allow = e_allow;
        v.e_ifid = e_ifid; v.e_pc = e_pc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic idle_inputs();
        leaving_pre_IF = 0; pc_pre_IF = '0; exception_pre_IF = 0; exccode_pre_IF = '0;
        tlb_refill_pre_IF = 0; inst_sram_data_ok = 0; inst_sram_rdata = '0;
        discard_instruction = 0; exception_like_now = 0; ID_allow_in = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " valid"},   32'(pre_IF_IF_reg_valid), 32'd0);
        chk({tag, " stall"},   32'(pre_IF_IF_reg_stall_wait_for_data), 32'd0);
        chk({tag, " ifid"},    32'(IF_ID_valid), 32'd0);
        chk({tag, " allow"},   32'(IF_allow_in), 32'd1);
        chk({tag, " pc"},      curr_pc_IF, 32'hBFBF_FFFC);
        chk({tag, " inst"},    inst_IF, 32'd0);
        chk({tag, " exc"},     32'(exception_IF), 32'd0);
        chk({tag, " exccode"}, 32'(exccode_IF), 32'd0);
        chk({tag, " tlb"},     32'(tlb_refill_IF), 32'd0);
`ifdef IF_PERF_CNT_EN
        chk({tag, " perf_wait"},    perf_wait_cycles, 32'd0);
        chk({tag, " perf_discard"}, perf_discards, 32'd0);
`endif
    endtask

    initial begin
        // Rows: entry inputs | beat/flush/ID inputs | expected valid, stall, allow_in, IF_ID_valid, pc, inst
        vecs[0]  = mk(1, 32'hBFC0_0000, 0, 0, 0, 1, 32'h2408_0001, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFBF_FFFC, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 32'hBFC0_0000, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h2408_0001, 0, 0, 1, 1, 1, 1, 1, 32'hBFC0_0000, 32'h2408_0001);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0000, 0);
        vecs[4]  = mk(1, 32'hBFC0_0000, 0, 0, 0, 1, 32'h2408_0001, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBFC0_0000, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'hBFC0_0000, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h2408_0001, 0, 0, 0, 1, 1, 0, 1, 32'hBFC0_0000, 32'h2408_0001);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hBFC0_0000, 32'h2408_0001);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hBFC0_0000, 32'h2408_0001);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 32'hBFC0_0000, 32'h2408_0001);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0000, 0);
        vecs[11] = mk(1, 32'hBFC0_0001, 1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBFC0_0000, 0);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'hBFC0_0001, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 32'hBFC0_0001, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0001, 0);
        vecs[15] = mk(1, 32'hBFC0_0008, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0001, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 32'hBFC0_0008, 0);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0, 1, 0, 0, 1, 0, 32'hBFC0_0008, 0);
        vecs[18] = mk(1, 32'hBFC0_0010, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 32'hBFC0_0008, 0);
        vecs[19] = mk(1, 32'hBFC0_000C, 0, 0, 0, 1, 32'h3C1D_0001, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0008, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h3C1D_0001, 0, 0, 1, 1, 1, 1, 1, 32'hBFC0_000C, 32'h3C1D_0001);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_000C, 0);
        vecs[22] = mk(1, 32'hBFC0_0000, 0, 0, 0, 1, 32'h1111_1111, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_000C, 0);
        vecs[23] = mk(1, 32'hBFC0_0004, 0, 0, 0, 1, 32'h2222_2222, 1, 32'h1111_1111, 0, 0, 1, 1, 1, 1, 1, 32'hBFC0_0000, 32'h1111_1111);
        vecs[24] = mk(1, 32'hBFC0_0008, 0, 0, 0, 1, 32'h3333_3333, 1, 32'h2222_2222, 0, 0, 1, 1, 1, 1, 1, 32'hBFC0_0004, 32'h2222_2222);
        vecs[25] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_3333, 0, 0, 1, 1, 1, 1, 1, 32'hBFC0_0008, 32'h3333_3333);
        vecs[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0008, 0);
        vecs[27] = mk(1, 32'hBFC0_0014, 1, 2, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'hBFC0_0008, 0);
        vecs[28] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 32'hBFC0_0014, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 32'hBFC0_0014, 0);

        reset = 1'b0;
        idle_inputs();
        #12;
        check_reset_values("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            leaving_pre_IF      = vecs[i].li;
            pc_pre_IF           = vecs[i].pc;
            exception_pre_IF    = vecs[i].exc;
            exccode_pre_IF      = vecs[i].code;
            tlb_refill_pre_IF   = vecs[i].tlb;
            inst_sram_data_ok   = vecs[i].dok;
            inst_sram_rdata     = vecs[i].rdata;
            discard_instruction = vecs[i].disc;
            exception_like_now  = vecs[i].exl;
            ID_allow_in         = vecs[i].ida;
            if (vecs[i].li && vecs[i].push) begin
                sb_t e;
                e.pc = vecs[i].pc; e.inst = vecs[i].sb_inst; e.exc = vecs[i].exc;
                e.code = vecs[i].code; e.tlb = vecs[i].tlb;
                sb_q.push_back(e);
            end
            @(negedge clk);
            if (inst_sram_data_ok && !discard_instruction && !pre_IF_IF_reg_stall_wait_for_data) begin
                n_mis++;
                $display("FAIL r%0d protocol: data beat outside WAIT without discard", i);
            end
            chk($sformatf("r%0d valid", i), 32'(pre_IF_IF_reg_valid), 32'(vecs[i].e_valid));
            chk($sformatf("r%0d stall", i), 32'(pre_IF_IF_reg_stall_wait_for_data), 32'(vecs[i].e_stall));
            chk($sformatf("r%0d allow_in", i), 32'(IF_allow_in), 32'(vecs[i].e_allow));
            chk($sformatf("r%0d IF_ID_valid", i), 32'(IF_ID_valid), 32'(vecs[i].e_ifid));
            chk($sformatf("r%0d leaving_IF", i), 32'(leaving_IF), 32'(vecs[i].e_ifid & vecs[i].ida));
            chk($sformatf("r%0d pc", i), curr_pc_IF, vecs[i].e_pc);
            if (vecs[i].e_ifid) chk($sformatf("r%0d inst", i), inst_IF, vecs[i].e_inst);
            if (leaving_IF) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_mis++;
                    $display("FAIL r%0d sb: leaving_IF with no expected entry", i);
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("r%0d sb pc", i), curr_pc_IF, e.pc);
                    chk($sformatf("r%0d sb inst", i), inst_IF, e.inst);
                    chk($sformatf("r%0d sb exc", i), 32'(exception_IF), 32'(e.exc));
                    chk($sformatf("r%0d sb exccode", i), 32'(exccode_IF), 32'(e.code));
                    chk($sformatf("r%0d sb tlb", i), 32'(tlb_refill_IF), 32'(e.tlb));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("sb drained", 32'(sb_q.size()), 32'd0);
`ifdef IF_PERF_CNT_EN
        chk("perf_wait count", perf_wait_cycles, 32'd3);
        chk("perf_discard count", perf_discards, 32'd1);
`endif

        // Asynchronous reset in the middle of a pending fetch.
        idle_inputs();
        leaving_pre_IF = 1; pc_pre_IF = 32'hBFC0_0018;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        chk("pre-reset stall", 32'(pre_IF_IF_reg_stall_wait_for_data), 32'd1);
        chk("pre-reset pc", curr_pc_IF, 32'hBFC0_0018);
        #2;
        reset = 1'b0;
        #1;
        check_reset_values("async reset");
        #10;
        reset = 1'b1;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
